// File: rtl/multi_debounce_pkg.sv
// Shared types and defaults for the multi-channel button debouncer.
// Holds the repeat FSM state encoding and a constant max() helper.
package multi_debounce_pkg;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    HELD = 2'd1,
    RPT  = 2'd2
  } rpt_state_e;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_STABLE_CYC = 16;
  localparam int DEF_HOLD_CYC   = 1000;
  localparam int DEF_REPEAT_CYC = 200;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: 2-flop synchronizer, stable counter, press/release pulses,
// and (with MULTI_DEBOUNCE_REPEAT_EN) a hold/auto-repeat FSM.
module db_channel
  import multi_debounce_pkg::*;
#(
  parameter int STABLE_CYC = DEF_STABLE_CYC
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  ,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int REPEAT_CYC = DEF_REPEAT_CYC
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rpt_o
);

  localparam int SCNT_W = $clog2(STABLE_CYC);
  localparam logic [SCNT_W-1:0] STABLE_LAST = SCNT_W'(STABLE_CYC - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;

  always_comb begin
    sync1_d   = raw_in;
    sync2_d   = sync1_q;
    scnt_d    = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Any cycle where the synced input agrees with the level restarts the count.
    if (sync2_q != level_q) begin
      if (scnt_q == STABLE_LAST) begin
        level_d   = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      scnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      scnt_q    <= scnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef MULTI_DEBOUNCE_REPEAT_EN
  localparam int HCNT_W = $clog2(max(HOLD_CYC, REPEAT_CYC));
  localparam logic [HCNT_W-1:0] HOLD_LAST   = HCNT_W'(HOLD_CYC - 1);
  localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_CYC - 1);

  rpt_state_e        state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              rpt_q, rpt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REL;
      hcnt_q  <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      rpt_q   <= rpt_d;
    end
  end

  // Events come from the same-edge accept decisions so the FSM tracks btn_level exactly.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    rpt_d   = 1'b0;
    case (state_q)
      REL: begin
        if (press_d) begin
          state_d = HELD;
          hcnt_d  = '0;
        end
      end
      HELD: begin
        if (release_d) begin
          state_d = REL;
          hcnt_d  = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          state_d = RPT;
          hcnt_d  = '0;
          rpt_d   = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      RPT: begin
        if (release_d) begin
          state_d = REL;
          hcnt_d  = '0;
        end else if (hcnt_q == REPEAT_LAST) begin
          hcnt_d = '0;
          rpt_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = REL;
        hcnt_d  = '0;
      end
    endcase
  end

  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

endmodule

// File: rtl/multi_debounce.sv
// N_CH independent button debouncers with press/release pulses and optional auto-repeat.
// Auto-repeat is built only when MULTI_DEBOUNCE_REPEAT_EN is defined; otherwise btn_rpt is 0.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int STABLE_CYC = DEF_STABLE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int REPEAT_CYC = DEF_REPEAT_CYC
) (
  input  logic            CP_1KHz,
  input  logic            RST,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_rpt
);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("multi_debounce: N_CH must be 1..16");
  end
  if (STABLE_CYC < 2 || STABLE_CYC > 256) begin : g_bad_stable
    $error("multi_debounce: STABLE_CYC must be 2..256");
  end
  if (HOLD_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_repeat
    $error("multi_debounce: HOLD_CYC and REPEAT_CYC must be at least 2");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    db_channel #(
      .STABLE_CYC(STABLE_CYC)
`ifdef MULTI_DEBOUNCE_REPEAT_EN
      ,
      .HOLD_CYC  (HOLD_CYC),
      .REPEAT_CYC(REPEAT_CYC)
`endif
    ) u_ch (
      .clk      (CP_1KHz),
      .rst      (RST),
      .raw_in   (btn_in[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .rpt_o    (btn_rpt[i])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Scoreboard bench: expected pulse events are queued when stimulus is driven and
// matched in order against every pulse the DUT emits.
module tb_multi_debounce;

  localparam int N_CH   = 4;
  localparam int STABLE = 16;
  localparam int HOLD   = 20;
  localparam int REPEAT = 5;
  localparam int K_PRESS = 0, K_REL = 1, K_RPT = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level, btn_press, btn_release, btn_rpt;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rpt_seen = 0;
  int   rpt_exp  = 0;
  ev_t  exp_q[$];

  logic        hit_m;
  logic [63:0] obs_m;
  ev_t         e_m;

  multi_debounce #(
    .N_CH      (N_CH),
    .STABLE_CYC(STABLE),
    .HOLD_CYC  (HOLD),
    .REPEAT_CYC(REPEAT)
  ) dut (
    .CP_1KHz    (clk),
    .RST        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_rpt    (btn_rpt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int kind, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.ch   = ch;
    exp_q.push_back(e);
    if (kind == K_RPT) rpt_exp++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every observed pulse is matched against the oldest expected event.
  always @(negedge clk) begin
    for (int ch = 0; ch < N_CH; ch++) begin
      for (int kd = 0; kd < 3; kd++) begin
        hit_m = (kd == K_PRESS) ? btn_press[ch] : (kd == K_REL) ? btn_release[ch] : btn_rpt[ch];
        if (hit_m === 1'b1) begin
          if (kd == K_RPT) rpt_seen++;
          obs_m = {32'(cyc), 16'(kd), 16'(ch)};
          if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", obs_m, 64'd0);
          end else begin
            e_m = exp_q.pop_front();
            check_eq("pulse", obs_m, {32'(e_m.cyc), 16'(e_m.kind), 16'(e_m.ch)});
          end
        end
      end
    end
  end

  initial begin
    int c;
    int p;
    int t;
    rst    = 1'b1;
    btn_in = '0;
    tick(3);
    check_eq("rst_level",   64'(btn_level),   64'd0);
    check_eq("rst_press",   64'(btn_press),   64'd0);
    check_eq("rst_release", 64'(btn_release), 64'd0);
    check_eq("rst_rpt",     64'(btn_rpt),     64'd0);
    rst = 1'b0;
    tick(2);

    // Single press on ch0: level and press exactly STABLE+1 edges after first sample.
    c = cyc;
    btn_in[0] = 1'b1;
    push_ev(c + 18, K_PRESS, 0);
    tick(17);
    check_eq("lat_level_early", 64'(btn_level[0]), 64'd0);
    tick(1);
    check_eq("lat_level", 64'(btn_level[0]), 64'd1);
    check_eq("lat_press", 64'(btn_press[0]), 64'd1);
    tick(1);
    check_eq("press_one_cycle", 64'(btn_press[0]), 64'd0);
    btn_in[0] = 1'b0;
    push_ev(c + 19 + 18, K_REL, 0);
    tick(25);

    // Glitches of 15 and 10 cycles on ch1 are rejected.
    btn_in[1] = 1'b1;
    tick(15);
    btn_in[1] = 1'b0;
    tick(25);
    check_eq("glitch15_level", 64'(btn_level), 64'd0);
    btn_in[1] = 1'b1;
    tick(10);
    btn_in[1] = 1'b0;
    tick(25);
    check_eq("glitch10_level", 64'(btn_level), 64'd0);

    // A 16-cycle pulse on ch3 is just long enough to be accepted.
    c = cyc;
    btn_in[3] = 1'b1;
    push_ev(c + 18, K_PRESS, 0 + 3);
    push_ev(c + 34, K_REL, 3);
    tick(16);
    btn_in[3] = 1'b0;
    tick(20);
    check_eq("pulse16_level", 64'(btn_level), 64'd0);

    // All four channels rise together; release accepted 40 cycles after the press.
    c = cyc;
    p = c + 18;
    btn_in = 4'b1111;
    for (int ch = 0; ch < N_CH; ch++) push_ev(p, K_PRESS, ch);
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    for (int r = 20; r <= 35; r += 5)
      for (int ch = 0; ch < N_CH; ch++) push_ev(p + r, K_RPT, ch);
`endif
    for (int ch = 0; ch < N_CH; ch++) push_ev(p + 40, K_REL, ch);
    tick(18);
    check_eq("multi_press", 64'(btn_press), 64'hF);
    check_eq("multi_level", 64'(btn_level), 64'hF);
    tick(22);
    btn_in = 4'b0000;
    tick(40);
    check_eq("multi_level_off", 64'(btn_level), 64'd0);

    // Long hold on ch0: repeats only when the repeat feature is built.
    c = cyc;
    p = c + 18;
    btn_in[0] = 1'b1;
    push_ev(p, K_PRESS, 0);
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    t = p + HOLD;
    while (t < c + 2018) begin
      push_ev(t, K_RPT, 0);
      t += REPEAT;
    end
`else
    t = 0;
`endif
    push_ev(c + 2018, K_REL, 0);
    tick(2000);
    check_eq("hold_level", 64'(btn_level[0]), 64'd1);
    btn_in[0] = 1'b0;
    tick(30);

    // ch2 debounced high, then reset mid-count of ch3: both need a fresh full latency.
    btn_in[2] = 1'b1;
    push_ev(cyc + 18, K_PRESS, 2);
    tick(25);
    c = cyc;
    btn_in[3] = 1'b1;
    tick(9);
    check_eq("pre_rst_level", 64'(btn_level), 64'h4);
    rst = 1'b1;
    tick(1);
    check_eq("mid_rst_outputs", {btn_level, btn_press, btn_release, btn_rpt}, 64'd0);
    rst = 1'b0;
    push_ev(c + 28, K_PRESS, 2);
    push_ev(c + 28, K_PRESS, 3);
    push_ev(c + 47, K_REL, 2);
    push_ev(c + 47, K_REL, 3);
    tick(17);
    check_eq("post_rst_level_early", 64'(btn_level), 64'd0);
    tick(1);
    check_eq("post_rst_press", 64'(btn_press), 64'hC);
    tick(1);
    btn_in = 4'b0000;
    tick(30);

    check_eq("events_pending", 64'(exp_q.size()), 64'd0);
    check_eq("rpt_count", 64'(rpt_seen), 64'(rpt_exp));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
